// File: rtl/sonata_pkg.sv
// Shared types and helpers for the board reset sequencer and its neighbours.
package sonata_pkg;

  localparam int RstCauseW  = 4;
  localparam int MaxDomains = 8;

  typedef enum logic [RstCauseW-1:0] {
    RstCausePor = 4'b0001,
    RstCauseBtn = 4'b0010,
    RstCausePll = 4'b0100,
    RstCauseSw  = 4'b1000
  } rst_cause_e;

  typedef enum logic [2:0] {
    WaitLock,
    Hold,
    Release,
    Run,
    SwHold,
    SwRelease
  } rst_seq_state_e;

  // Lowest set bit at or above 'start'; returns MaxDomains when there is none.
  function automatic logic [3:0] next_set_idx(input logic [MaxDomains-1:0] bits,
                                              input logic [3:0] start);
    logic [3:0] idx;
    logic       found;
    idx   = 4'(MaxDomains);
    found = 1'b0;
    for (int i = 0; i < MaxDomains; i++) begin
      if (!found && bits[i] && (4'(i) >= start)) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser followed by a stability counter; reports the accepted
// level and a one-cycle pulse on each accepted rising edge.
module rst_debounce #(
  parameter int DebounceCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntAccept = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  // Restart the stability count on any change, accept the level once it has held long enough.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q != last_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_q >= CntAccept) begin
        level_d = last_q;
      end
    end
    rise_d = level_d & ~level_q;
  end

  // State registers for the synchroniser, counter and accepted level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: waits for a stable PLL lock, then releases the
// active-low domain resets one by one, and re-enters reset on lock loss, a
// debounced button press or a masked software request.
module rst_seq_ctrl
  import sonata_pkg::*;
#(
  parameter int NumDomains     = 3,
  parameter int HoldCycles     = 255,
  parameter int StaggerCycles  = 16,
  parameter int DebounceCycles = 1024,
  parameter int SwHoldCycles   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pll_locked_i,
  input  logic                  rst_btn_i,
  input  logic                  sw_rst_req_i,
  input  logic [NumDomains-1:0] sw_rst_mask_i,
  output logic [NumDomains-1:0] rst_domain_no,
  output logic                  rst_active_o,
  output logic [RstCauseW-1:0]  reset_cause_o
);

  localparam int MaxHs  = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
  localparam int MaxCnt = (MaxHs > SwHoldCycles) ? MaxHs : SwHoldCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MaxCnt);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(StaggerCycles - 1);
  localparam logic [CntW-1:0] SwLast   = CntW'(SwHoldCycles - 1);
  localparam logic [3:0]      LastIdx  = 4'(NumDomains - 1);

  logic                  lock_sync1_q, lock_sync1_d;
  logic                  lock_sync2_q, lock_sync2_d;
  logic                  btn_level, btn_rise, btn_event;
  rst_seq_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [3:0]            idx_q, idx_d;
  logic [NumDomains-1:0] mask_q, mask_d;
  logic [NumDomains-1:0] dom_q, dom_d;
  logic                  active_q, active_d;
  rst_cause_e            cause_q, cause_d;
  logic [MaxDomains-1:0] mask_ext;
  logic [3:0]            first_idx, later_idx;
  logic                  rel_en;
  logic [3:0]            rel_idx;
  logic                  abort;

  rst_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_btn_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (rst_btn_i),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // The rise pulse is always accompanied by a high accepted level; qualifying keeps both in use.
  assign btn_event = btn_rise & btn_level;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign abort     = (state_q != WaitLock) && (state_q != Hold) && (!lock_sync2_q || btn_event);

  // Widen the latched software mask so the shared index search can scan it.
  always_comb begin
    mask_ext                 = '0;
    mask_ext[NumDomains-1:0] = mask_q;
  end

  assign first_idx = next_set_idx(mask_ext, 4'd0);
  assign later_idx = next_set_idx(mask_ext, idx_q + 4'd1);

  // Next-state, counter and domain-reset computation; aborts override everything.
  always_comb begin
    lock_sync1_d = pll_locked_i;
    lock_sync2_d = lock_sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    dom_d        = dom_q;
    cause_d      = cause_q;
    rel_en       = 1'b0;
    rel_idx      = 4'd0;

    case (state_q)
      WaitLock: begin
        dom_d = '0;
        cnt_d = '0;
        idx_d = 4'd0;
        if (lock_sync2_q) state_d = Hold;
      end
      Hold: begin
        dom_d = '0;
        if (!lock_sync2_q) begin
          state_d = WaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = Release;
          idx_d   = 4'd0;
          cnt_d   = '0;
          rel_en  = 1'b1;
          rel_idx = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      Release: begin
        if (idx_q == LastIdx) begin
          state_d = Run;
          cnt_d   = '0;
        end else if (cnt_q == StagLast) begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          rel_en  = 1'b1;
          rel_idx = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      Run: begin
        dom_d = '1;
        cnt_d = '0;
        if (sw_rst_req_i && (|sw_rst_mask_i)) begin
          state_d = SwHold;
          mask_d  = sw_rst_mask_i;
          dom_d   = ~sw_rst_mask_i;
          cause_d = RstCauseSw;
        end
      end
      SwHold: begin
        if (cnt_q == SwLast) begin
          state_d = SwRelease;
          idx_d   = first_idx;
          cnt_d   = '0;
          rel_en  = 1'b1;
          rel_idx = first_idx;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SwRelease: begin
        if (later_idx >= 4'(NumDomains)) begin
          state_d = Run;
          cnt_d   = '0;
        end else if (cnt_q == StagLast) begin
          idx_d   = later_idx;
          cnt_d   = '0;
          rel_en  = 1'b1;
          rel_idx = later_idx;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = WaitLock;
        dom_d   = '0;
        cnt_d   = '0;
        idx_d   = 4'd0;
      end
    endcase

    for (int i = 0; i < NumDomains; i++) begin
      if (rel_en && (rel_idx == 4'(i))) dom_d[i] = 1'b1;
    end

    if (abort) begin
      state_d = WaitLock;
      dom_d   = '0;
      cnt_d   = '0;
      idx_d   = 4'd0;
      cause_d = !lock_sync2_q ? RstCausePll : RstCauseBtn;
    end

    active_d = ~&dom_d;
  end

  // Register the FSM, counters and the glitch-free reset outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync1_q <= 1'b0;
      lock_sync2_q <= 1'b0;
      state_q      <= WaitLock;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      mask_q       <= '0;
      dom_q        <= '0;
      active_q     <= 1'b1;
      cause_q      <= RstCausePor;
    end else begin
      lock_sync1_q <= lock_sync1_d;
      lock_sync2_q <= lock_sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      dom_q        <= dom_d;
      active_q     <= active_d;
      cause_q      <= cause_d;
    end
  end

  assign rst_domain_no = dom_q;
  assign rst_active_o  = active_q;
  assign reset_cause_o = cause_q;

endmodule
